// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - screen flow FSM, pixel x/y split and wiped RGB565 mux for the 96x64 OLED
module screen_sequencer #(
    parameter int NUM_SCREENS = 9,
    parameter int WIPE_STEP   = 8,
    parameter int HOLD_FRAMES = 120
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      frame_begin,
    input  logic [12:0]               pixel_index,
    input  logic                      btn_start,
    input  logic                      level_done,
    input  logic                      game_over,
    input  logic [16*NUM_SCREENS-1:0] screen_data,
    output logic [6:0]                x,
    output logic [5:0]                y,
    output logic [15:0]               oled_data,
    output logic [3:0]                cur_screen,
    output logic                      transitioning
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, WIPE = 2'd2, HOLD = 2'd3} state_t;

    localparam logic [3:0] LAST_SCR  = 4'(NUM_SCREENS - 1);
    localparam logic [3:0] LAST_LVL  = 4'(NUM_SCREENS - 2);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] STEP8     = 8'(WIPE_STEP);
    localparam logic [6:0] FULL      = 7'd96;

    state_t     state, state_d, ret_state, ret_d;
    logic [3:0] cur_d, nxt, nxt_d, sel;
    logic [6:0] wipe_col, wipe_d, wipe_sat;
    logic [7:0] hold_cnt, hold_d, wipe_sum;
    logic [15:0] pix;
    logic [12:0] row, col_full;
    logic        unused_bits;

    assign row         = pixel_index / 13'd96;
    assign col_full    = pixel_index - row * 13'd96;
    assign y           = row[5:0];
    assign x           = col_full[6:0];
    assign unused_bits = ^{row[12:6], col_full[12:7]};

    // Slots beyond NUM_SCREENS read as black so any select index is safe.
    logic [15:0] scr [16];
    for (genvar k = 0; k < 16; k++) begin : g_scr
        if (k < NUM_SCREENS) begin : g_on
            assign scr[k] = screen_data[16*k +: 16];
        end else begin : g_off
            assign scr[k] = 16'h0000;
        end
    end

    assign sel           = (state == WIPE && x < wipe_col) ? nxt : cur_screen;
    assign pix           = scr[sel];
    assign transitioning = (state == WIPE);

    assign wipe_sum = {1'b0, wipe_col} + STEP8;
    assign wipe_sat = (wipe_sum >= 8'd96) ? FULL : wipe_sum[6:0];

    always_comb begin
        state_d = state;
        ret_d   = ret_state;
        cur_d   = cur_screen;
        nxt_d   = nxt;
        wipe_d  = wipe_col;
        hold_d  = hold_cnt;
        case (state)
            IDLE: if (btn_start) begin
                nxt_d   = 4'd1;
                ret_d   = PLAY;
                state_d = WIPE;
            end
            PLAY: if (game_over) begin
                nxt_d   = LAST_SCR;
                ret_d   = HOLD;
                state_d = WIPE;
            end else if (level_done) begin
                if (cur_screen < LAST_LVL) begin
                    nxt_d = cur_screen + 4'd1;
                    ret_d = PLAY;
                end else begin
                    nxt_d = LAST_SCR;
                    ret_d = HOLD;
                end
                state_d = WIPE;
            end
            // The extra frame at wipe_col==96 shows the full new screen before committing.
            WIPE: if (frame_begin) begin
                if (wipe_col == FULL) begin
                    cur_d   = nxt;
                    wipe_d  = 7'd0;
                    state_d = ret_state;
                    if (ret_state == HOLD) hold_d = 8'd0;
                end else begin
                    wipe_d = wipe_sat;
                end
            end
            HOLD: if (frame_begin) begin
                hold_d = hold_cnt + 8'd1;
                if (hold_cnt == HOLD_LAST) begin
                    nxt_d   = 4'd0;
                    ret_d   = IDLE;
                    state_d = WIPE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            ret_state  <= IDLE;
            cur_screen <= 4'd0;
            nxt        <= 4'd0;
            wipe_col   <= 7'd0;
            hold_cnt   <= 8'd0;
            oled_data  <= 16'h0000;
        end else begin
            state      <= state_d;
            ret_state  <= ret_d;
            cur_screen <= cur_d;
            nxt        <= nxt_d;
            wipe_col   <= wipe_d;
            hold_cnt   <= hold_d;
            oled_data  <= pix;
        end
    end
endmodule

// File: tb/tb_screen_sequencer.sv
// tb/tb_screen_sequencer.sv - directed self-checking bench for screen_sequencer
module tb_screen_sequencer;
    localparam int NS = 9;
    localparam logic [15:0] SCR [NS] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'hF81F,
                                         16'h07FF, 16'h1234, 16'hABCD, 16'h5555};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n = 1'b0;
    logic           frame_begin = 1'b0;
    logic [12:0]    pixel_index = 13'd0;
    logic           btn_start = 1'b0;
    logic           level_done = 1'b0;
    logic           game_over = 1'b0;
    logic [16*NS-1:0] screen_data;
    logic [6:0]     x;
    logic [5:0]     y;
    logic [15:0]    oled_data;
    logic [3:0]     cur_screen;
    logic           transitioning;

    for (genvar k = 0; k < NS; k++) begin : g_sd
        assign screen_data[16*k +: 16] = SCR[k];
    end

    screen_sequencer #(.NUM_SCREENS(NS), .WIPE_STEP(8), .HOLD_FRAMES(4)) dut (
        .clk(clk), .reset_n(reset_n), .frame_begin(frame_begin), .pixel_index(pixel_index),
        .btn_start(btn_start), .level_done(level_done), .game_over(game_over),
        .screen_data(screen_data), .x(x), .y(y), .oled_data(oled_data),
        .cur_screen(cur_screen), .transitioning(transitioning)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_begin = 1'b1;
            tick();
            frame_begin = 1'b0;
        end
    endtask

    task automatic pix(input string tag, input int idx, input logic [15:0] exp);
        pixel_index = 13'(idx);
        tick();
        chk(tag, 32'(oled_data), 32'(exp));
    endtask

    task automatic lvl();
        level_done = 1'b1;
        tick();
        level_done = 1'b0;
        frames(13);
    endtask

    task automatic start();
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
    endtask

    initial begin
        // reset
        repeat (3) tick();
        chk("rst_oled", 32'(oled_data), 32'h0);
        chk("rst_cur", 32'(cur_screen), 32'd0);
        chk("rst_trans", 32'(transitioning), 32'd0);
        reset_n = 1'b1;
        pix("rst_pix0", 0, 16'hF800);

        // x/y split
        pixel_index = 13'd200; #1;
        chk("x_200", 32'(x), 32'd8);
        chk("y_200", 32'(y), 32'd2);
        pixel_index = 13'd96; #1;
        chk("x_96", 32'(x), 32'd0);
        chk("y_96", 32'(y), 32'd1);
        pixel_index = 13'd6143; #1;
        chk("x_6143", 32'(x), 32'd95);
        chk("y_6143", 32'(y), 32'd63);

        // start wipe to screen 1
        start();
        chk("start_trans", 32'(transitioning), 32'd1);
        frames(1);
        pix("wipe_x7", 7, 16'h07E0);
        pix("wipe_x8", 8, 16'hF800);
        pix("wipe_x95", 95, 16'hF800);
        frames(11);
        chk("wipe12_cur", 32'(cur_screen), 32'd0);
        chk("wipe12_trans", 32'(transitioning), 32'd1);
        pix("wipe12_x95", 95, 16'h07E0);
        frames(1);
        chk("wipe13_cur", 32'(cur_screen), 32'd1);
        chk("wipe13_trans", 32'(transitioning), 32'd0);
        chk("wipe13_state", 32'(dut.state), 32'd1);

        // event coincident with frame_begin: counter starts on the next frame
        level_done = 1'b1;
        frame_begin = 1'b1;
        tick();
        level_done = 1'b0;
        frame_begin = 1'b0;
        chk("coinc_wipe_col", 32'(dut.wipe_col), 32'd0);
        chk("coinc_nxt", 32'(dut.nxt), 32'd2);
        frames(13);
        chk("lvl2_cur", 32'(cur_screen), 32'd2);

        // level_done mid-wipe is ignored
        level_done = 1'b1;
        tick();
        level_done = 1'b0;
        frames(5);
        level_done = 1'b1;
        tick();
        level_done = 1'b0;
        chk("mid_nxt", 32'(dut.nxt), 32'd3);
        frames(8);
        chk("lvl3_cur", 32'(cur_screen), 32'd3);
        chk("lvl3_state", 32'(dut.state), 32'd1);

        // game_over beats level_done
        level_done = 1'b1;
        game_over = 1'b1;
        tick();
        level_done = 1'b0;
        game_over = 1'b0;
        chk("prio_nxt", 32'(dut.nxt), 32'd8);
        chk("prio_trans", 32'(transitioning), 32'd1);
        frames(13);
        chk("prio_cur", 32'(cur_screen), 32'd8);
        chk("prio_state", 32'(dut.state), 32'd3);

        // hold timeout
        frames(3);
        chk("hold3_trans", 32'(transitioning), 32'd0);
        frames(1);
        chk("hold4_trans", 32'(transitioning), 32'd1);
        chk("hold4_nxt", 32'(dut.nxt), 32'd0);
        frames(13);
        chk("ret_cur", 32'(cur_screen), 32'd0);
        chk("ret_state", 32'(dut.state), 32'd0);

        // level chain to the end screen
        start();
        frames(13);
        repeat (6) lvl();
        chk("chain_cur7", 32'(cur_screen), 32'd7);
        lvl();
        chk("chain_cur8", 32'(cur_screen), 32'd8);
        chk("chain_state", 32'(dut.state), 32'd3);
        pix("end_x0", 0, 16'h5555);
        pix("end_x50", 50, 16'h5555);
        pix("end_x95", 6143, 16'h5555);

        // btn_start ignored in HOLD
        start();
        chk("hold_btn_state", 32'(dut.state), 32'd3);
        chk("hold_btn_trans", 32'(transitioning), 32'd0);
        frames(4 + 13);
        chk("idle2_state", 32'(dut.state), 32'd0);

        // reset mid-wipe
        start();
        frames(5);
        chk("mid_wipe_col", 32'(dut.wipe_col), 32'd40);
        pix("mid_x39", 39, 16'h07E0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mrst_cur", 32'(cur_screen), 32'd0);
        chk("mrst_wipe_col", 32'(dut.wipe_col), 32'd0);
        chk("mrst_trans", 32'(transitioning), 32'd0);
        chk("mrst_state", 32'(dut.state), 32'd0);
        pix("mrst_x0", 0, 16'hF800);
        pix("mrst_x39", 39, 16'hF800);
        pix("mrst_x95", 95, 16'hF800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
